burst_memory: RTL and testbench
===============================

BURST_MEMORY -- requirements
Module: burst_memory

Interface
REQ-001 Parameter DEPTH_BYTES, default 1048576: byte capacity of the storage array.
REQ-002 Parameter BASE_ADDR, default 32'h80020000: byte address mapped to array index 0.
REQ-003 Parameter MAX_BEATS, default 16: longest burst supported (power of two, at least 8).
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  request strobe; accepted only when busy=0.
REQ-007 rw  input  1  1=read, 0=write; sampled at acceptance.
REQ-008 address  input  32  start byte address; sampled at acceptance.
REQ-009 access_size  input  2  burst length: 00=1, 01=4, 10=8, 11=16 beats of 32 bits.
REQ-010 width_sel  input  2  00=word, 01=halfword, 10=byte, 11=reserved (error).
REQ-011 load_signed  input  1  1 sign-extends sub-word loads; 0 zero-extends.
REQ-012 data_in  input  32  write data for the current beat.
REQ-013 flush  input  1  aborts any request in progress (branch or exception kill).
REQ-014 busy  output  1  high while burst beats after the first are pending.
REQ-015 data_out  output  32  registered read data.
REQ-016 data_valid  output  1  high for exactly the cycles in which data_out holds a read beat.
REQ-017 err  output  1  one-cycle pulse on a rejected request.

Function
REQ-018 The FSM SHALL have three states: IDLE, RD_BURST and WR_BURST.
REQ-019 A request SHALL be accepted in cycle T when enable=1, busy=0 and flush=0; beat 0 is performed at the edge ending T.
REQ-020 Beat k SHALL address start+4k; N = 1, 4, 8 or 16 beats as selected by access_size; an access_size selecting more than MAX_BEATS beats SHALL be rejected.
REQ-021 For N>1, busy SHALL be 1 in cycles T+1..T+N-1, and the FSM SHALL return to IDLE after beat N-1; for N=1, busy SHALL stay 0.
REQ-022 Writes SHALL sample data_in at each beat edge, storing big-endian with bits [31:24] at the lowest byte address.
REQ-023 Reads SHALL present beat k on data_out with data_valid=1 in cycle T+1+k.
REQ-024 Sub-word accesses SHALL be legal only when N=1.
REQ-025 A byte access SHALL use bits [7:0] of data_in (write) or of data_out (read).
REQ-026 A halfword access SHALL use bits [15:0], with the lower byte address mapping to bits [15:8].
REQ-027 Loads SHALL be extended to 32 bits per load_signed.
REQ-028 A request SHALL be rejected with err=1 in T+1, no array access and state remaining IDLE, if any of the following holds:
- address is misaligned for width_sel (word requires [1:0]=0, halfword requires [0]=0);
- width_sel=11;
- a sub-word access has N>1;
- any byte of the burst lies outside [BASE_ADDR, BASE_ADDR+DEPTH_BYTES).
REQ-029 flush=1 in any cycle SHALL:
- cancel all not-yet-performed beats;
- force data_out=0 and data_valid=0 at that edge;
- return the FSM to IDLE with busy=0 next cycle.
Beats already written SHALL remain written.
REQ-030 enable asserted while busy=1 SHALL be ignored, not queued.
REQ-031 A new request MAY be accepted in the cycle busy falls; its data_valid SHALL follow the previous burst's last beat with no gap.
REQ-032 data_out SHALL hold its last value when data_valid=0, except after flush (REQ-029).

Reset
REQ-033 On reset=1 at a rising edge, the block SHALL:
- enter IDLE;
- set busy=0, data_valid=0, err=0 and data_out=0;
- clear the beat counter.
Reset SHALL abort a burst mid-operation like flush; array contents are not cleared.
REQ-034 reset SHALL take priority over flush, and flush over enable.

Structure
REQ-035 A shared package SHALL hold:
- the FSM state enum;
- the access_size and width_sel encodings;
- the beats-per-access_size lookup constant.
REQ-036 One sub-module, mem_lane_align, SHALL perform big-endian byte-lane selection, write-byte enables and load extension combinationally.

Verification
REQ-037 Word write then read, 0x80020000, data 0xDEADBEEF: data_out=0xDEADBEEF with data_valid in T+1; busy never high.
REQ-038 4-beat write of 0x11111111..0x44444444 at 0x80020010, then 4-beat read: data_valid for 4 consecutive cycles with the same values in order; busy high for 3 cycles each.
REQ-039 Store byte 0x80 to 0x80020003 over word 0: load_signed=1 returns 0xFFFFFF80, load_signed=0 returns 0x00000080; word read returns 0x00000080.
REQ-040 Halfword read at 0x80020001: err=1 one cycle, data_valid=0, busy=0.
REQ-041 8-beat write with flush in the cycle of beat 3: beats 0-2 stored, beats 3-7 unchanged, busy=0 next cycle.
REQ-042 reset asserted during a 16-beat read at beat 5: data_valid=0, data_out=0 and busy=0 next cycle; a subsequent single read succeeds.

Source files
------------

// File: rtl/burst_memory_pkg.sv
// Shared encodings for the burst memory: FSM states, request field encodings
// and the beats-per-access_size lookup.
package burst_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RD_BURST = 2'b01,
    ST_WR_BURST = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    AS_1  = 2'b00,
    AS_4  = 2'b01,
    AS_8  = 2'b10,
    AS_16 = 2'b11
  } access_size_e;

  typedef enum logic [1:0] {
    WS_WORD = 2'b00,
    WS_HALF = 2'b01,
    WS_BYTE = 2'b10,
    WS_RSVD = 2'b11
  } width_sel_e;

  // Indexed directly by access_size.
  localparam logic [4:0] BEATS_LUT [4] = '{5'd1, 5'd4, 5'd8, 5'd16};

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: write data replication and byte enables,
// plus sub-word extraction and sign/zero extension of loads.
module mem_lane_align
  import burst_memory_pkg::*;
(
  input  logic [1:0]  i_width_sel,
  input  logic [1:0]  i_byte_off,
  input  logic        i_load_signed,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_rd_word,
  output logic [31:0] o_wr_word,
  output logic [3:0]  o_wr_be,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // Byte offset 0 lives in bits [31:24], so lane = 3 - offset.
    w_byte    = i_rd_word[{~i_byte_off, 3'b000} +: 8];
    w_half    = i_byte_off[1] ? i_rd_word[15:0] : i_rd_word[31:16];
    o_wr_word = i_wr_data;
    o_wr_be   = 4'hF;
    o_ld_data = i_rd_word;
    case (i_width_sel)
      WS_HALF: begin
        o_wr_word = {2{i_wr_data[15:0]}};
        o_wr_be   = i_byte_off[1] ? 4'b0011 : 4'b1100;
        o_ld_data = {{16{i_load_signed & w_half[15]}}, w_half};
      end
      WS_BYTE: begin
        o_wr_word = {4{i_wr_data[7:0]}};
        o_wr_be   = 4'b0001 << ~i_byte_off;
        o_ld_data = {{24{i_load_signed & w_byte[7]}}, w_byte};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/burst_memory.sv
// Single-port burst memory: 1/4/8/16-beat word bursts or single sub-word
// accesses, big-endian storage, with flush and request validation.
module burst_memory
  import burst_memory_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1048576,
  parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
  parameter int unsigned MAX_BEATS   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        rw,
  input  logic [31:0] address,
  input  logic [1:0]  access_size,
  input  logic [1:0]  width_sel,
  input  logic        load_signed,
  input  logic [31:0] data_in,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        err
);

  localparam int unsigned WORDS = DEPTH_BYTES / 4;
  localparam int unsigned AW    = $clog2(WORDS);

  logic [31:0]   r_mem [WORDS];
  state_e        r_state;
  logic [AW-1:0] r_idx;
  logic [4:0]    r_beat;
  logic [4:0]    r_last;
  logic [31:0]   r_data_out;
  logic          r_valid;
  logic          r_err;

  logic [4:0]    w_beats;
  logic [32:0]   w_off;
  logic [32:0]   w_bytes;
  logic [32:0]   w_end;
  logic          w_misalign;
  logic          w_req_err;
  logic          w_idle;
  logic          w_accept;
  logic          w_wr_en;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_width;
  logic [1:0]    w_byte_off;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_wr_word;
  logic [3:0]    w_be;
  logic [31:0]   w_ld_data;

  always_comb begin
    w_beats = BEATS_LUT[access_size];
    // Bit 32 set means the address lies below BASE_ADDR.
    w_off   = {1'b0, address} - {1'b0, BASE_ADDR};
    case (width_sel)
      WS_HALF: begin
        w_bytes    = 33'd2;
        w_misalign = address[0];
      end
      WS_BYTE: begin
        w_bytes    = 33'd1;
        w_misalign = 1'b0;
      end
      default: begin
        w_bytes    = {26'd0, w_beats, 2'b00};
        w_misalign = (address[1:0] != 2'b00);
      end
    endcase
    w_end     = w_off + w_bytes;
    w_req_err = w_misalign || (width_sel == WS_RSVD) ||
                ((width_sel != WS_WORD) && (w_beats != 5'd1)) ||
                (32'(w_beats) > MAX_BEATS) ||
                w_off[32] || (w_end > 33'(DEPTH_BYTES));
    w_idle     = (r_state == ST_IDLE);
    w_accept   = enable && w_idle && !flush && !reset;
    w_idx      = w_idle ? AW'(w_off >> 2) : r_idx;
    w_width    = w_idle ? width_sel : WS_WORD;
    w_byte_off = w_idle ? address[1:0] : 2'b00;
    w_wr_en    = !reset && !flush &&
                 ((w_accept && !w_req_err && !rw) || (r_state == ST_WR_BURST));
  end

  assign w_rd_word = r_mem[w_idx];

  mem_lane_align u_align (
    .i_width_sel   (w_width),
    .i_byte_off    (w_byte_off),
    .i_load_signed (load_signed),
    .i_wr_data     (data_in),
    .i_rd_word     (w_rd_word),
    .o_wr_word     (w_wr_word),
    .o_wr_be       (w_be),
    .o_ld_data     (w_ld_data)
  );

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wr_word[8*i +: 8];
      end
    end
  end

  // Reset and flush both abandon the burst and blank the read port.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_state    <= ST_IDLE;
      r_beat     <= 5'd0;
      r_last     <= 5'd0;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_data_out <= 32'd0;
    end else if (w_idle) begin
      r_err   <= w_accept && w_req_err;
      r_valid <= w_accept && !w_req_err && rw;
      if (w_accept && !w_req_err && rw) r_data_out <= w_ld_data;
      if (w_accept && !w_req_err && (w_beats != 5'd1)) begin
        r_state <= rw ? ST_RD_BURST : ST_WR_BURST;
        r_beat  <= 5'd1;
        r_last  <= w_beats - 5'd1;
        r_idx   <= w_idx + 1'b1;
      end
    end else begin
      r_err   <= 1'b0;
      r_valid <= (r_state == ST_RD_BURST);
      if (r_state == ST_RD_BURST) r_data_out <= w_ld_data;
      r_idx  <= r_idx + 1'b1;
      r_beat <= r_beat + 5'd1;
      if (r_beat == r_last) begin
        r_state <= ST_IDLE;
        r_beat  <= 5'd0;
      end
    end
  end

  assign busy       = !w_idle;
  assign data_out   = r_data_out;
  assign data_valid = r_valid;
  assign err        = r_err;

endmodule

// File: tb/tb_burst_memory.sv
// Directed self-checking bench for burst_memory: one task per scenario.
module tb_burst_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        rw;
  logic [31:0] address;
  logic [1:0]  access_size;
  logic [1:0]  width_sel;
  logic        load_signed;
  logic [31:0] data_in;
  logic        flush;
  logic        busy;
  logic [31:0] data_out;
  logic        data_valid;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  burst_memory dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .rw          (rw),
    .address     (address),
    .access_size (access_size),
    .width_sel   (width_sel),
    .load_signed (load_signed),
    .data_in     (data_in),
    .flush       (flush),
    .busy        (busy),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .err         (err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic r, input logic [31:0] a, input logic [1:0] sz,
                     input logic [1:0] ws, input logic sgn, input logic [31:0] d);
    enable      = 1'b1;
    rw          = r;
    address     = a;
    access_size = sz;
    width_sel   = ws;
    load_signed = sgn;
    data_in     = d;
  endtask

  task automatic write1(input logic [31:0] a, input logic [1:0] ws, input logic [31:0] d);
    req(1'b0, a, 2'b00, ws, 1'b0, d);
    tick();
    enable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; flush = 1'b0; rw = 1'b0; address = 32'd0;
    access_size = 2'b00; width_sel = 2'b00; load_signed = 1'b0; data_in = 32'd0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (data_out !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", data_out); end
  endtask

  task automatic test_word();
    req(1'b0, 32'h8002_0000, 2'b00, 2'b00, 1'b0, 32'hDEAD_BEEF);
    tick();
    enable = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL word_wr_busy got=%b exp=0", busy); end
    req(1'b1, 32'h8002_0000, 2'b00, 2'b00, 1'b0, 32'd0);
    tick();
    enable = 1'b0;
    checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL word_rd_valid got=%b exp=1", data_valid); end
    checks++; if (data_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL word_rd_data got=%h exp=deadbeef", data_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL word_rd_busy got=%b exp=0", busy); end
    tick();
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL word_hold_valid got=%b exp=0", data_valid); end
    checks++; if (data_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL word_hold_data got=%h exp=deadbeef", data_out); end
  endtask

  task automatic test_burst_write();
    logic [31:0] d;
    req(1'b0, 32'h8002_0010, 2'b01, 2'b00, 1'b0, 32'h1111_1111);
    tick();
    enable = 1'b0;
    for (int k = 1; k < 4; k++) begin
      d = 32'h1111_1111 * (k + 1);
      data_in = d;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bwr_busy[%0d] got=%b exp=1", k, busy); end
      checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL bwr_valid[%0d] got=%b exp=0", k, data_valid); end
      tick();
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bwr_busy_end got=%b exp=0", busy); end
  endtask

  // 4-beat read with a second request held on enable: ignored while busy,
  // accepted in the cycle busy falls, its data following with no gap.
  task automatic test_back_to_back();
    logic [31:0] d;
    logic        b;
    req(1'b1, 32'h8002_0010, 2'b01, 2'b00, 1'b0, 32'd0);
    tick();
    address = 32'h8002_0000; access_size = 2'b00;
    for (int k = 0; k < 4; k++) begin
      d = 32'h1111_1111 * (k + 1);
      b = (k < 3);
      checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", k, data_valid); end
      checks++; if (data_out !== d) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, data_out, d); end
      checks++; if (busy !== b) begin failures++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", k, busy, b); end
      tick();
    end
    enable = 1'b0;
    checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL b2b_next_valid got=%b exp=1", data_valid); end
    checks++; if (data_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b_next_data got=%h exp=deadbeef", data_out); end
    tick();
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL b2b_after_valid got=%b exp=0", data_valid); end
  endtask

  task automatic test_subword();
    logic [31:0] ta [6];
    logic [1:0]  tw [6];
    logic        ts [6];
    logic [31:0] te [6];
    write1(32'h8002_0000, 2'b00, 32'd0);
    write1(32'h8002_0003, 2'b10, 32'h0000_0080);
    write1(32'h8002_0004, 2'b00, 32'h0102_0304);
    write1(32'h8002_0006, 2'b01, 32'h0000_A5C3);
    ta = '{32'h8002_0003, 32'h8002_0003, 32'h8002_0000, 32'h8002_0006, 32'h8002_0004, 32'h8002_0004};
    tw = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    ts = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    te = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0080, 32'hFFFF_A5C3, 32'h0000_0102, 32'h0102_A5C3};
    for (int i = 0; i < 6; i++) begin
      req(1'b1, ta[i], 2'b00, tw[i], ts[i], 32'd0);
      tick();
      checks++; if (data_valid !== 1'b1 || data_out !== te[i]) begin
        failures++; $display("FAIL subword[%0d] got=%h valid=%b exp=%h", i, data_out, data_valid, te[i]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_errors();
    logic        er [6];
    logic [31:0] ea [6];
    logic [1:0]  es [6];
    logic [1:0]  ew [6];
    er = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ea = '{32'h8002_0001, 32'h8002_0000, 32'h8002_0000, 32'h8001_FFFC, 32'h8011_FFF8, 32'h8002_0002};
    es = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
    ew = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 6; i++) begin
      req(er[i], ea[i], es[i], ew[i], 1'b0, 32'hFFFF_FFFF);
      tick();
      enable = 1'b0;
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_pulse[%0d] got=%b exp=1", i, err); end
      checks++; if (data_valid !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL err_side[%0d] got valid=%b busy=%b exp 0/0", i, data_valid, busy);
      end
      tick();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear[%0d] got=%b exp=0", i, err); end
    end
    req(1'b1, 32'h8002_0000, 2'b00, 2'b00, 1'b0, 32'd0);
    tick();
    enable = 1'b0;
    checks++; if (data_out !== 32'h0000_0080) begin failures++; $display("FAIL err_no_write got=%h exp=00000080", data_out); end
    write1(32'h8011_FFFC, 2'b00, 32'hCAFE_F00D);
    req(1'b1, 32'h8011_FFFC, 2'b00, 2'b00, 1'b0, 32'd0);
    tick();
    enable = 1'b0;
    checks++; if (err !== 1'b0 || data_valid !== 1'b1 || data_out !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL last_word got=%h err=%b valid=%b exp=cafef00d", data_out, err, data_valid);
    end
    req(1'b1, 32'h8011_FFF0, 2'b01, 2'b00, 1'b0, 32'd0);
    tick();
    enable = 1'b0;
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL end_burst got err=%b busy=%b exp 0/1", err, busy);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_flush();
    logic [31:0] d;
    req(1'b0, 32'h8002_0040, 2'b10, 2'b00, 1'b0, 32'hAAAA_0000);
    tick();
    enable = 1'b0;
    for (int k = 1; k < 8; k++) begin
      data_in = 32'hAAAA_0000 + k;
      tick();
    end
    req(1'b0, 32'h8002_0040, 2'b10, 2'b00, 1'b0, 32'h5555_0000);
    tick();
    enable = 1'b0;
    data_in = 32'h5555_0001;
    tick();
    data_in = 32'h5555_0002;
    tick();
    data_in = 32'h5555_0003;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
    req(1'b1, 32'h8002_0040, 2'b10, 2'b00, 1'b0, 32'd0);
    tick();
    enable = 1'b0;
    for (int k = 0; k < 8; k++) begin
      d = (k < 3) ? (32'h5555_0000 + k) : (32'hAAAA_0000 + k);
      checks++; if (data_valid !== 1'b1 || data_out !== d) begin
        failures++; $display("FAIL flush_mem[%0d] got=%h valid=%b exp=%h", k, data_out, data_valid, d);
      end
      tick();
    end
    req(1'b1, 32'h8002_0040, 2'b01, 2'b00, 1'b0, 32'd0);
    tick();
    enable = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (data_valid !== 1'b0 || data_out !== 32'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL flush_read got=%h valid=%b busy=%b exp=00000000/0/0", data_out, data_valid, busy);
    end
    tick();
    checks++; if (data_valid !== 1'b0 || data_out !== 32'd0) begin
      failures++; $display("FAIL flush_hold got=%h valid=%b exp=00000000/0", data_out, data_valid);
    end
  endtask

  task automatic test_reset_mid();
    req(1'b1, 32'h8002_0040, 2'b11, 2'b00, 1'b0, 32'd0);
    tick();
    enable = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (data_valid !== 1'b1 || data_out !== 32'hAAAA_0004) begin
      failures++; $display("FAIL rst_mid_beat4 got=%h valid=%b exp=aaaa0004", data_out, data_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (data_valid !== 1'b0 || data_out !== 32'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_mid got=%h valid=%b busy=%b exp=00000000/0/0", data_out, data_valid, busy);
    end
    req(1'b1, 32'h8002_0040, 2'b00, 2'b00, 1'b0, 32'd0);
    tick();
    enable = 1'b0;
    checks++; if (data_valid !== 1'b1 || data_out !== 32'h5555_0000 || err !== 1'b0) begin
      failures++; $display("FAIL rst_after_read got=%h valid=%b err=%b exp=55550000", data_out, data_valid, err);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_burst_write();
    test_back_to_back();
    test_subword();
    test_errors();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
